// File: rtl/gpio_write_arbiter.sv
// Pin/pindir write arbiter: merges per-SM mapped writes with a host bus write,
// forces a starved bus write through, counts SM collisions, synchronizes pads.
module gpio_write_arbiter #(
  parameter int NUM_SM       = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SM*32-1:0]  in_smPinsWriteData,
  input  logic [NUM_SM*32-1:0]  in_smPinsWriteMask,
  input  logic [NUM_SM*32-1:0]  in_smPinDirsWriteData,
  input  logic [NUM_SM*32-1:0]  in_smPinDirsWriteMask,
  input  logic [NUM_SM-1:0]     in_smEnable,
  input  logic                  in_busWriteValid,
  input  logic                  in_busWriteSel,
  input  logic [31:0]           in_busWriteData,
  input  logic [31:0]           in_busWriteMask,
  output logic                  out_busWriteReady,
  input  logic [31:0]           in_GPIO,
  input  logic [31:0]           in_syncBypass,
  output logic [31:0]           out_GPIO,
  output logic [31:0]           out_GPIOOutEnable,
  output logic [31:0]           out_GPIOSync,
  input  logic                  in_collisionClear,
  output logic [7:0]            out_collisionCount
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} bus_state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  bus_state_e  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  coll_q, coll_d;
  logic [31:0] pins_q, pins_d, dirs_q, dirs_d;
  logic [31:0] sync1_q, sync2_q;

  logic [31:0] smp_mask, smp_data, smd_mask, smd_data;
  logic [31:0] collp, colld, mp, md;
  logic        collision, overlap, ready, accept, force_w;
  logic [31:0] bus_p, bus_d;

  function automatic logic [31:0] merge(input logic [31:0] q,
                                        input logic [31:0] lo_m, input logic [31:0] lo_d,
                                        input logic [31:0] hi_m, input logic [31:0] hi_d);
    return (((q & ~lo_m) | (lo_d & lo_m)) & ~hi_m) | (hi_d & hi_m);
  endfunction

  // Later (higher-index) SMs overwrite earlier ones; any bit seen twice is a collision.
  always_comb begin
    smp_mask = '0;
    smp_data = '0;
    smd_mask = '0;
    smd_data = '0;
    collp    = '0;
    colld    = '0;
    mp       = '0;
    md       = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      if (in_smEnable[i] && !reset) begin
        mp       = in_smPinsWriteMask[32*i +: 32];
        md       = in_smPinDirsWriteMask[32*i +: 32];
        collp    = collp | (smp_mask & mp);
        colld    = colld | (smd_mask & md);
        smp_data = (smp_data & ~mp) | (in_smPinsWriteData[32*i +: 32] & mp);
        smd_data = (smd_data & ~md) | (in_smPinDirsWriteData[32*i +: 32] & md);
        smp_mask = smp_mask | mp;
        smd_mask = smd_mask | md;
      end
    end
  end

  assign collision = (|collp) | (|colld);
  assign overlap   = |((in_busWriteSel ? smd_mask : smp_mask) & in_busWriteMask);
  assign force_w   = (state_q == FORCE);

  always_comb begin
    ready = 1'b0;
    if (!reset) ready = force_w ? 1'b1 : !overlap;
  end

  assign accept = in_busWriteValid && ready;
  assign bus_p  = (accept && !in_busWriteSel) ? in_busWriteMask : '0;
  assign bus_d  = (accept &&  in_busWriteSel) ? in_busWriteMask : '0;

  // In FORCE the bus wins over SMs; otherwise SMs win (no overlap unless mask is 0 anyway).
  always_comb begin
    if (force_w) begin
      pins_d = merge(pins_q, smp_mask, smp_data, bus_p, in_busWriteData);
      dirs_d = merge(dirs_q, smd_mask, smd_data, bus_d, in_busWriteData);
    end else begin
      pins_d = merge(pins_q, bus_p, in_busWriteData, smp_mask, smp_data);
      dirs_d = merge(dirs_q, bus_d, in_busWriteData, smd_mask, smd_data);
    end
  end

  // The stalled IDLE cycle counts as the first of STARVE_LIMIT stalled cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      IDLE: begin
        if (in_busWriteValid && !ready) begin
          if (LIMIT <= 8'd1) state_d = FORCE;
          else begin
            state_d = WAIT;
            wait_d  = 8'd1;
          end
        end
      end
      WAIT: begin
        if (!in_busWriteValid || ready) state_d = IDLE;
        else if (wait_q + 8'd1 >= LIMIT) state_d = FORCE;
        else wait_d = wait_q + 8'd1;
      end
      FORCE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coll_d = coll_q;
    if (in_collisionClear) coll_d = collision ? 8'd1 : 8'd0;
    else if (collision && coll_q != 8'hFF) coll_d = coll_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      coll_q  <= '0;
      pins_q  <= '0;
      dirs_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      coll_q  <= coll_d;
      pins_q  <= pins_d;
      dirs_q  <= dirs_d;
      sync1_q <= in_GPIO;
      sync2_q <= sync1_q;
    end
  end

  assign out_busWriteReady  = ready;
  assign out_GPIO           = pins_q;
  assign out_GPIOOutEnable  = dirs_q;
  assign out_GPIOSync       = (in_syncBypass & in_GPIO) | (~in_syncBypass & sync2_q);
  assign out_collisionCount = coll_q;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Directed bench for gpio_write_arbiter: priority, bus handshake, starvation force,
// sync bypass, collision counter saturation/clear and reset during WAIT.
module tb_gpio_write_arbiter;
  localparam int NUM_SM = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_SM*32-1:0] pd, pm, dd, dm;
  logic [NUM_SM-1:0] en;
  logic bv, bsel, bready;
  logic [31:0] bdata, bmask, gpio_in, bypass, gpio_out, gpio_oe, gpio_sync;
  logic cclr;
  logic [7:0] ccount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpio_write_arbiter #(.NUM_SM(NUM_SM), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset(reset),
    .in_smPinsWriteData(pd), .in_smPinsWriteMask(pm),
    .in_smPinDirsWriteData(dd), .in_smPinDirsWriteMask(dm),
    .in_smEnable(en),
    .in_busWriteValid(bv), .in_busWriteSel(bsel),
    .in_busWriteData(bdata), .in_busWriteMask(bmask),
    .out_busWriteReady(bready),
    .in_GPIO(gpio_in), .in_syncBypass(bypass),
    .out_GPIO(gpio_out), .out_GPIOOutEnable(gpio_oe), .out_GPIOSync(gpio_sync),
    .in_collisionClear(cclr), .out_collisionCount(ccount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sm();
    pd = '0; pm = '0; dd = '0; dm = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_sm(); en = '1;
    bv = 1'b1; bsel = 1'b0; bdata = '0; bmask = '0;
    gpio_in = '0; bypass = '0; cclr = 1'b0;
    tick(); tick();
    tests++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL reset_gpio got %h want %h", gpio_out, 32'h0); end
    tests++; if (gpio_oe !== 32'h0) begin fails++; $display("FAIL reset_oe got %h want %h", gpio_oe, 32'h0); end
    tests++; if (bready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bready); end
    tests++; if (ccount !== 8'd0) begin fails++; $display("FAIL reset_coll got %0d want 0", ccount); end
    tests++; if (gpio_sync !== 32'h0) begin fails++; $display("FAIL reset_sync got %h want 0", gpio_sync); end
    reset = 1'b0; bv = 1'b0;
    tick();
  endtask

  task automatic test_sm_priority();
    pm[0*32 +: 32] = 32'h0000_00FF; pd[0*32 +: 32] = 32'h0000_00A5;
    pm[2*32 +: 32] = 32'h0000_000F; pd[2*32 +: 32] = 32'h0000_0003;
    tick();
    clear_sm();
    tests++; if (gpio_out !== 32'h0000_00A3) begin fails++; $display("FAIL sm_priority got %h want %h", gpio_out, 32'h0000_00A3); end
    tests++; if (ccount !== 8'd1) begin fails++; $display("FAIL sm_collision got %0d want 1", ccount); end
  endtask

  task automatic test_bus_pindirs();
    bv = 1'b1; bsel = 1'b1; bmask = 32'h0000_FF00; bdata = 32'h0000_FFFF;
    #1;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL bus_ready got %b want 1", bready); end
    tick();
    bv = 1'b0;
    tests++; if (gpio_oe !== 32'h0000_FF00) begin fails++; $display("FAIL bus_pindirs got %h want %h", gpio_oe, 32'h0000_FF00); end
    tick();
    tests++; if (gpio_oe !== 32'h0000_FF00) begin fails++; $display("FAIL pindirs_hold got %h want %h", gpio_oe, 32'h0000_FF00); end
  endtask

  task automatic test_disabled_sm();
    en = 4'b0111;
    pm[3*32 +: 32] = 32'hF000_0000; pd[3*32 +: 32] = 32'hFFFF_FFFF;
    tick();
    clear_sm(); en = '1;
    tests++; if (gpio_out !== 32'h0000_00A3) begin fails++; $display("FAIL disabled_sm got %h want %h", gpio_out, 32'h0000_00A3); end
  endtask

  task automatic test_bus_merge();
    pm[1*32 +: 32] = 32'h0000_00FF; pd[1*32 +: 32] = 32'h0;
    bv = 1'b1; bsel = 1'b0; bmask = 32'h0; bdata = 32'h0;
    #1;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL mask0_ready got %b want 1", bready); end
    bmask = 32'h0000_0001; #1;
    tests++; if (bready !== 1'b0) begin fails++; $display("FAIL overlap_ready got %b want 0", bready); end
    bmask = 32'h0000_0100; bdata = 32'h0000_0100; #1;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL disjoint_ready got %b want 1", bready); end
    tick();
    bv = 1'b0; clear_sm();
    tests++; if (gpio_out !== 32'h0000_0100) begin fails++; $display("FAIL bus_merge got %h want %h", gpio_out, 32'h0000_0100); end
  endtask

  task automatic test_starve();
    pm[1*32 +: 32] = 32'h1; pd[1*32 +: 32] = 32'h0;
    bv = 1'b1; bsel = 1'b0; bmask = 32'h1; bdata = 32'h1;
    for (int i = 0; i < 15; i++) begin
      #1;
      tests++; if (bready !== 1'b0) begin fails++; $display("FAIL starve_ready cyc %0d got %b want 0", i, bready); end
      tick();
    end
    #1;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL force_ready got %b want 1", bready); end
    tick();
    bv = 1'b0;
    tests++; if (gpio_out[0] !== 1'b1) begin fails++; $display("FAIL force_write got %b want 1", gpio_out[0]); end
    tick();
    tests++; if (gpio_out[0] !== 1'b0) begin fails++; $display("FAIL after_force got %b want 0", gpio_out[0]); end
    clear_sm();
  endtask

  task automatic test_sync();
    gpio_in = 32'hFFFF_FFFF; bypass = 32'h0000_0001;
    #1;
    tests++; if (gpio_sync !== 32'h0000_0001) begin fails++; $display("FAIL sync_bypass got %h want %h", gpio_sync, 32'h1); end
    tick();
    tests++; if (gpio_sync !== 32'h0000_0001) begin fails++; $display("FAIL sync_edge1 got %h want %h", gpio_sync, 32'h1); end
    tick();
    tests++; if (gpio_sync !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sync_edge2 got %h want %h", gpio_sync, 32'hFFFF_FFFF); end
  endtask

  task automatic test_collision_sat();
    pm[0*32 +: 32] = 32'h8000_0000; pm[1*32 +: 32] = 32'h8000_0000;
    for (int i = 0; i < 300; i++) tick();
    tests++; if (ccount !== 8'd255) begin fails++; $display("FAIL coll_sat got %0d want 255", ccount); end
    cclr = 1'b1;
    tick();
    tests++; if (ccount !== 8'd1) begin fails++; $display("FAIL coll_clr_hit got %0d want 1", ccount); end
    clear_sm();
    tick();
    cclr = 1'b0;
    tests++; if (ccount !== 8'd0) begin fails++; $display("FAIL coll_clr got %0d want 0", ccount); end
  endtask

  task automatic test_reset_in_wait();
    pm[1*32 +: 32] = 32'h1; pd[1*32 +: 32] = 32'h1;
    dm[2*32 +: 32] = 32'h4; dd[2*32 +: 32] = 32'h4;
    bv = 1'b1; bsel = 1'b0; bmask = 32'h1; bdata = 32'h0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    #1;
    tests++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL rst_wait_gpio got %h want 0", gpio_out); end
    tests++; if (gpio_oe !== 32'h0) begin fails++; $display("FAIL rst_wait_oe got %h want 0", gpio_oe); end
    tests++; if (bready !== 1'b0) begin fails++; $display("FAIL rst_wait_ready got %b want 0", bready); end
    tests++; if (gpio_sync !== 32'h0000_0001) begin fails++; $display("FAIL rst_wait_sync got %h want %h", gpio_sync, 32'h1); end
    tick();
    tests++; if (gpio_out !== 32'h0) begin fails++; $display("FAIL rst_ignore_sm got %h want 0", gpio_out); end
    reset = 1'b0; clear_sm();
    #1;
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b want 1", bready); end
    bv = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sm_priority();
    test_bus_pindirs();
    test_disabled_sm();
    test_bus_merge();
    test_starve();
    test_sync();
    test_collision_sat();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
